// File: rtl/mcycle_core_param.sv
// mcycle_core_param
// Multi-cycle MIPS-subset CPU core with a parametrised datapath width.
// A 32-bit big-endian instruction is fetched as 32/DATA_W beats over a shared
// request/grant bus. Each instruction then passes through DECODE and EXEC, and
// optionally MEM (one DATA_W-wide access) and WB (register write), before the
// next fetch. An illegal opcode parks the core in HALT until reset.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   bus_req    bus request, held until granted
//   bus_gnt    one-cycle grant; bus_rdata is valid in the same cycle
//   bus_we     1 = write, 0 = read (valid while bus_req)
//   bus_addr   byte address (valid while bus_req)
//   bus_wdata  write data (valid while bus_req && bus_we)
//   bus_rdata  read data, sampled only when a request is granted
//   halted     sticky flag, set on an illegal opcode
//   dbg_pc     current program counter
module mcycle_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

  localparam int BEATS  = 32 / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RIDX_W = $clog2(NREG);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_ALU   = 6'd0;
  localparam logic [5:0] OP_JMP   = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LOAD  = 6'd32;
  localparam logic [5:0] OP_STORE = 6'd40;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_XOR = 6'd38;
  localparam logic [5:0] FN_SLT = 6'd42;

  // 16-bit immediate sign-extended (or truncated) to the datapath width.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [15:0] v);
    return DATA_W'($signed(v));
  endfunction

  // Datapath value resized to an address, keeping its sign (branch offsets).
  function automatic logic [ADDR_W-1:0] sext_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'($signed(v));
  endfunction

  // Datapath value resized to an address as an unsigned quantity.
  function automatic logic [ADDR_W-1:0] zext_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  logic [2:0]        state;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [NREG];
  logic              wb_en;

  logic signed [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0]        imm;
  logic [DATA_W-1:0]        res;
  logic [RIDX_W-1:0]        wb_idx;

  logic [5:0]        opcode, func;
  logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ok;
  logic [DATA_W-1:0] eff_sum;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] beq_tgt;
  logic [ADDR_W-1:0] jmp_tgt;

  assign opcode = ir[31:26];
  assign func   = ir[5:0];
  assign rs_idx = ir[21 +: RIDX_W];
  assign rt_idx = ir[16 +: RIDX_W];
  assign rd_idx = ir[11 +: RIDX_W];

  // r0 always reads as zero regardless of storage contents.
  assign rs_val = (rs_idx == '0) ? '0 : regs[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : regs[rt_idx];

  assign eff_sum  = opa + imm;
  assign eff_addr = zext_addr(eff_sum);
  // PC already points past the branch when EXEC runs.
  assign beq_tgt  = (opa == opb) ? (pc + sext_addr(imm)) : pc;
  assign jmp_tgt  = ir[ADDR_W-1:0];

  assign dbg_pc = pc;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (func)
      FN_ADD:  alu_res = opa + opb;
      FN_SUB:  alu_res = opa - opb;
      FN_AND:  alu_res = opa & opb;
      FN_OR:   alu_res = opa | opb;
      FN_XOR:  alu_res = opa ^ opb;
      FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
      default: alu_ok  = 1'b0;
    endcase
  end

  // Operand / result registers: pure data, no reset needed.
  always_ff @(posedge clk) begin
    // DECODE: latch register operands and the extended immediate
    if (state == S_DECODE) begin
      opa <= $signed(rs_val);
      opb <= $signed(rt_val);
      imm <= sext_imm(ir[15:0]);
    end
    // EXEC: ALU / ADDI result and destination index
    if (state == S_EXEC) begin
      wb_idx <= (opcode == OP_ALU) ? rd_idx : rt_idx;
      res    <= (opcode == OP_ALU) ? alu_res : eff_sum;
    end
    // MEM: load data replaces the result
    if (state == S_MEM && bus_req && bus_gnt && !bus_we) begin
      res <= bus_rdata;
    end
  end

  // Control, architectural state and registered bus outputs.
  // Whenever the next state is FETCH the first beat request is issued on the
  // same edge, so back-to-back accesses cost exactly two cycles each.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      beat      <= '0;
      pc        <= '0;
      ir        <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      halted    <= 1'b0;
      wb_en     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus_req && bus_gnt) begin
            ir[31 - DATA_W * int'(beat) -: DATA_W] <= bus_rdata;
            pc <= pc + PC_STEP;
            if (beat == BEAT_W'(BEATS - 1)) begin
              beat    <= '0;
              bus_req <= 1'b0;
              state   <= S_DECODE;
            end else begin
              beat     <= beat + 1'b1;
              bus_addr <= pc + PC_STEP;
            end
          end else if (!bus_req) begin
            // Only reached straight after reset.
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= pc;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ALU, OP_JMP, OP_BEQ, OP_ADDI, OP_LOAD, OP_STORE: state <= S_EXEC;
            default: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_ALU: begin
              wb_en <= alu_ok;
              state <= S_WB;
            end
            OP_ADDI: begin
              wb_en <= 1'b1;
              state <= S_WB;
            end
            OP_JMP: begin
              pc       <= jmp_tgt;
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= jmp_tgt;
              state    <= S_FETCH;
            end
            OP_BEQ: begin
              pc       <= beq_tgt;
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= beq_tgt;
              state    <= S_FETCH;
            end
            OP_LOAD: begin
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= eff_addr;
              state    <= S_MEM;
            end
            OP_STORE: begin
              bus_req   <= 1'b1;
              bus_we    <= 1'b1;
              bus_addr  <= eff_addr;
              bus_wdata <= opb;
              state     <= S_MEM;
            end
            default: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (bus_req && bus_gnt) begin
            if (bus_we) begin
              // Store done: go straight to the next fetch.
              bus_we   <= 1'b0;
              bus_addr <= pc;
              state    <= S_FETCH;
            end else begin
              bus_req <= 1'b0;
              wb_en   <= 1'b1;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_en && wb_idx != '0) regs[wb_idx] <= res;
          wb_en    <= 1'b0;
          bus_req  <= 1'b1;
          bus_we   <= 1'b0;
          bus_addr <= pc;
          state    <= S_FETCH;
        end
        S_HALT: begin
          bus_req <= 1'b0;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_core_param.sv
// Testbench for mcycle_core_param: an 8-bit instance and a 32-bit instance,
// each served by a memory/arbiter model. Expected bus writes and fetch
// addresses are queued when a program is loaded and compared as the DUT
// performs the accesses.
module tb_mcycle_core_param;

  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LOAD  = 6'd32;
  localparam logic [5:0] OP_STORE = 6'd40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset8, gnt8, req8, we8, halted8;
  logic [7:0] addr8, wdata8, rdata8, pc8;

  logic        reset32, gnt32, req32, we32, halted32;
  logic [7:0]  addr32, pc32;
  logic [31:0] wdata32, rdata32;

  mcycle_core_param #(.DATA_W(8), .ADDR_W(8), .NREG(8)) dut8 (
    .clk(clk), .reset(reset8), .bus_req(req8), .bus_gnt(gnt8), .bus_we(we8),
    .bus_addr(addr8), .bus_wdata(wdata8), .bus_rdata(rdata8),
    .halted(halted8), .dbg_pc(pc8)
  );

  mcycle_core_param #(.DATA_W(32), .ADDR_W(8), .NREG(8)) dut32 (
    .clk(clk), .reset(reset32), .bus_req(req32), .bus_gnt(gnt32), .bus_we(we32),
    .bus_addr(addr32), .bus_wdata(wdata32), .bus_rdata(rdata32),
    .halted(halted32), .dbg_pc(pc32)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string      name;
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } alu_vec_t;

  logic [7:0]  mem8  [256];
  logic [31:0] mem32 [64];
  wr_t         exp_wr8[$];
  wr_t         exp_wr32[$];
  logic [7:0]  exp_fetch8[$];
  logic [7:0]  exp_fetch32[$];
  int          delay8 = 1;
  int          n_checks = 0;
  int          n_fail = 0;
  string       cur_test = "init";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [7:0] tgt);
    return {6'd2, 18'd0, tgt};
  endfunction

  task automatic put8(input int a, input logic [31:0] instr);
    mem8[8'(a)]     = instr[31:24];
    mem8[8'(a + 1)] = instr[23:16];
    mem8[8'(a + 2)] = instr[15:8];
    mem8[8'(a + 3)] = instr[7:0];
  endtask

  task automatic put32(input int a, input logic [31:0] instr);
    mem32[6'(a >> 2)] = instr;
  endtask

  task automatic exp_w8(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr8.push_back(w);
  endtask

  task automatic exp_w32(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr32.push_back(w);
  endtask

  task automatic score_wr(input bit is32, input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    if ((is32 ? exp_wr32.size() : exp_wr8.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/unexpected_write: got addr %0h data %0h expected no write", cur_test, a, d);
    end else begin
      w = is32 ? exp_wr32.pop_front() : exp_wr8.pop_front();
      chk("wr_addr", 32'(a), 32'(w.addr));
      chk("wr_data", d, w.data);
    end
  endtask

  // Memory / arbiter model for the 8-bit instance.
  initial begin
    int         age;
    logic [7:0] s_addr, s_wdata;
    logic       s_we;
    logic [7:0] ea;
    age = 0; gnt8 = 1'b0; rdata8 = '0; s_addr = '0; s_wdata = '0; s_we = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset8) begin
        gnt8 = 1'b0;
        age  = 0;
      end else if (gnt8) begin
        gnt8 = 1'b0;
        age  = req8 ? 1 : 0;
        s_addr = addr8; s_we = we8; s_wdata = wdata8;
      end else if (req8) begin
        if (age == 0) begin
          s_addr = addr8; s_we = we8; s_wdata = wdata8;
        end else begin
          chk("stable_addr", 32'(addr8), 32'(s_addr));
          chk("stable_we", 32'(we8), 32'(s_we));
          if (s_we) chk("stable_wdata", 32'(wdata8), 32'(s_wdata));
        end
        if (age >= delay8) begin
          gnt8 = 1'b1;
          if (we8) begin
            mem8[addr8] = wdata8;
            score_wr(1'b0, addr8, 32'(wdata8));
          end else begin
            rdata8 = mem8[addr8];
            if (exp_fetch8.size() > 0) begin
              ea = exp_fetch8.pop_front();
              chk("fetch_addr", 32'(addr8), 32'(ea));
            end
          end
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Memory / arbiter model for the 32-bit instance (fixed one-cycle grant).
  initial begin
    int         age;
    logic [7:0] ea;
    age = 0; gnt32 = 1'b0; rdata32 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset32) begin
        gnt32 = 1'b0;
        age   = 0;
      end else if (gnt32) begin
        gnt32 = 1'b0;
        age   = req32 ? 1 : 0;
      end else if (req32) begin
        if (age >= 1) begin
          gnt32 = 1'b1;
          if (we32) begin
            mem32[addr32[7:2]] = wdata32;
            score_wr(1'b1, addr32, wdata32);
          end else begin
            rdata32 = mem32[addr32[7:2]];
            if (exp_fetch32.size() > 0) begin
              ea = exp_fetch32.pop_front();
              chk("fetch32_addr", 32'(addr32), 32'(ea));
            end
          end
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic prog_begin8(input string name);
    reset8   = 1'b1;
    delay8   = 1;
    cur_test = name;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) mem8[i] = '0;
    exp_wr8.delete();
    exp_fetch8.delete();
  endtask

  task automatic drain8(input int maxc);
    int c;
    c = 0;
    while ((exp_wr8.size() != 0 || exp_fetch8.size() != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (exp_wr8.size() != 0 || exp_fetch8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/timeout: got %0d writes %0d fetches pending expected 0", cur_test,
               exp_wr8.size(), exp_fetch8.size());
    end
  endtask

  task automatic drain32(input int maxc);
    int c;
    c = 0;
    while ((exp_wr32.size() != 0 || exp_fetch32.size() != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (exp_wr32.size() != 0 || exp_fetch32.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/timeout: got %0d writes %0d fetches pending expected 0", cur_test,
               exp_wr32.size(), exp_fetch32.size());
    end
  endtask

  task automatic load_t1_prog();
    put8(0,  enc_i(OP_ADDI, 0, 1, 16'h0005));
    put8(4,  enc_i(OP_ADDI, 0, 2, 16'hFFFD));
    put8(8,  enc_r(3, 1, 2, 6'd32));
    put8(12, enc_i(OP_STORE, 0, 3, 16'h0080));
    put8(16, enc_i(OP_STORE, 0, 1, 16'h0081));
    put8(20, enc_i(OP_STORE, 0, 2, 16'h0082));
    put8(24, enc_j(8'd24));
  endtask

  alu_vec_t vecs [10];

  initial begin
    logic any_req;
    bit   found;

    vecs[0] = '{"add",      6'd32, 8'h0F, 8'hF0, 8'hFF};
    vecs[1] = '{"sub",      6'd34, 8'h0F, 8'hF0, 8'h1F};
    vecs[2] = '{"and",      6'd36, 8'h0F, 8'hF0, 8'h00};
    vecs[3] = '{"or",       6'd37, 8'h0F, 8'hF0, 8'hFF};
    vecs[4] = '{"xor",      6'd38, 8'h0F, 8'hF0, 8'hFF};
    vecs[5] = '{"slt_pos",  6'd42, 8'h0F, 8'hF0, 8'h00};
    vecs[6] = '{"slt_neg",  6'd42, 8'hF0, 8'h0F, 8'h01};
    vecs[7] = '{"add_wrap", 6'd32, 8'h80, 8'h80, 8'h00};
    vecs[8] = '{"sub_wrap", 6'd34, 8'h00, 8'h01, 8'hFF};
    vecs[9] = '{"func_nop", 6'd63, 8'h12, 8'h34, 8'h55};

    reset8  = 1'b1;
    reset32 = 1'b1;

    // Reset state
    cur_test = "reset";
    repeat (3) @(negedge clk);
    chk("req",    32'(req8),    32'd0);
    chk("we",     32'(we8),     32'd0);
    chk("addr",   32'(addr8),   32'd0);
    chk("wdata",  32'(wdata8),  32'd0);
    chk("halted", 32'(halted8), 32'd0);
    chk("pc",     32'(pc8),     32'd0);
    chk("req32",  32'(req32),   32'd0);
    chk("pc32",   32'(pc32),    32'd0);

    // ADDI / ADD with byte-sequential fetch addresses
    prog_begin8("addi_add");
    load_t1_prog();
    for (int i = 0; i < 28; i++) exp_fetch8.push_back(8'(i));
    exp_w8(8'h80, 32'h02);
    exp_w8(8'h81, 32'h05);
    exp_w8(8'h82, 32'hFD);
    reset8 = 1'b0;
    drain8(1000);

    // ALU table
    for (int i = 0; i < 10; i++) begin
      prog_begin8(vecs[i].name);
      put8(0,  enc_i(OP_ADDI, 0, 1, {8'h00, vecs[i].a}));
      put8(4,  enc_i(OP_ADDI, 0, 2, {8'h00, vecs[i].b}));
      put8(8,  enc_i(OP_ADDI, 0, 3, 16'h0055));
      put8(12, enc_r(3, 1, 2, vecs[i].fn));
      put8(16, enc_i(OP_STORE, 0, 3, 16'h0080));
      put8(20, enc_j(8'd20));
      exp_w8(8'h80, 32'(vecs[i].exp));
      reset8 = 1'b0;
      drain8(1000);
    end

    // Writes to r0 are discarded
    prog_begin8("r0_zero");
    put8(0,  enc_i(OP_ADDI, 0, 0, 16'h0007));
    put8(4,  enc_i(OP_ADDI, 0, 1, 16'h0009));
    put8(8,  enc_i(OP_STORE, 0, 0, 16'h0080));
    put8(12, enc_i(OP_STORE, 0, 1, 16'h0081));
    put8(16, enc_j(8'd16));
    exp_w8(8'h80, 32'h00);
    exp_w8(8'h81, 32'h09);
    reset8 = 1'b0;
    drain8(1000);

    // BEQ taken backwards: loops at 0x10
    prog_begin8("beq_loop");
    put8(0,  enc_i(OP_ADDI, 0, 1, 16'h0001));
    put8(4,  enc_i(OP_ADDI, 0, 2, 16'h0002));
    put8(8,  enc_i(OP_ADDI, 0, 3, 16'h0003));
    put8(12, enc_i(OP_ADDI, 0, 4, 16'h0004));
    put8(16, enc_i(OP_BEQ, 1, 1, 16'hFFFC));
    for (int i = 0; i < 20; i++) exp_fetch8.push_back(8'(i));
    for (int k = 0; k < 3; k++)
      for (int i = 16; i < 20; i++) exp_fetch8.push_back(8'(i));
    reset8 = 1'b0;
    drain8(1000);

    // BEQ not taken: falls through to 0x14
    prog_begin8("beq_fall");
    put8(0,  enc_i(OP_ADDI, 0, 1, 16'h0001));
    put8(4,  enc_i(OP_ADDI, 0, 2, 16'h0002));
    put8(8,  enc_i(OP_ADDI, 0, 3, 16'h0003));
    put8(12, enc_i(OP_ADDI, 0, 4, 16'h0004));
    put8(16, enc_i(OP_BEQ, 1, 2, 16'h0008));
    put8(20, enc_i(OP_STORE, 0, 1, 16'h0080));
    put8(24, enc_j(8'd24));
    put8(28, enc_i(OP_STORE, 0, 2, 16'h0080));
    for (int i = 0; i < 28; i++) exp_fetch8.push_back(8'(i));
    exp_w8(8'h80, 32'h01);
    reset8 = 1'b0;
    drain8(1000);

    // STORE then LOAD via base+negative offset, grant delayed 5 cycles
    prog_begin8("ld_st_delay");
    delay8 = 5;
    put8(0,  enc_i(OP_ADDI, 0, 1, 16'h005A));
    put8(4,  enc_i(OP_ADDI, 0, 5, 16'h0090));
    put8(8,  enc_i(OP_STORE, 5, 1, 16'hFFF0));
    put8(12, enc_i(OP_LOAD, 5, 4, 16'hFFF0));
    put8(16, enc_i(OP_STORE, 0, 4, 16'h0081));
    put8(20, enc_j(8'd20));
    exp_w8(8'h80, 32'h5A);
    exp_w8(8'h81, 32'h5A);
    reset8 = 1'b0;
    drain8(3000);

    // Illegal opcode halts and keeps the bus idle
    prog_begin8("illegal");
    put8(0, enc_i(OP_ADDI, 0, 1, 16'h0001));
    put8(4, enc_i(OP_STORE, 0, 1, 16'h0080));
    put8(8, 32'hFC00_0000);
    exp_w8(8'h80, 32'h01);
    reset8 = 1'b0;
    drain8(1000);
    repeat (20) @(negedge clk);
    chk("halted", 32'(halted8), 32'd1);
    chk("pc",     32'(pc8),     32'h0C);
    any_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_req = any_req | req8;
    end
    chk("req_idle", 32'(any_req), 32'd0);

    // Reset during a fetch beat
    prog_begin8("reset_mid");
    load_t1_prog();
    reset8 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (req8 && addr8 == 8'd2) found = 1'b1;
    end
    chk("reached_beat2", 32'(found), 32'd1);
    chk("pc_before", 32'(pc8), 32'd2);
    reset8 = 1'b1;
    @(negedge clk);
    chk("req", 32'(req8),    32'd0);
    chk("pc",  32'(pc8),     32'd0);
    chk("halted", 32'(halted8), 32'd0);

    // 32-bit datapath: single-beat fetch, wide ADD, PC wrap via BEQ
    cur_test = "w32";
    for (int i = 0; i < 64; i++) mem32[i] = '0;
    exp_wr32.delete();
    exp_fetch32.delete();
    put32(8'h00, enc_j(8'h10));
    put32(8'h04, enc_i(OP_STORE, 0, 2, 16'h0044));
    put32(8'h08, enc_j(8'h08));
    put32(8'h10, enc_i(OP_ADDI, 0, 1, 16'h7FFF));
    put32(8'h14, enc_r(2, 1, 1, 6'd32));
    put32(8'h18, enc_i(OP_STORE, 0, 2, 16'h0040));
    put32(8'h1C, enc_j(8'hFC));
    put32(8'hFC, enc_i(OP_BEQ, 0, 0, 16'h0004));
    exp_fetch32.push_back(8'h00);
    exp_fetch32.push_back(8'h10);
    exp_fetch32.push_back(8'h14);
    exp_fetch32.push_back(8'h18);
    exp_fetch32.push_back(8'h1C);
    exp_fetch32.push_back(8'hFC);
    exp_fetch32.push_back(8'h04);
    exp_fetch32.push_back(8'h08);
    exp_w32(8'h40, 32'h0000_FFFE);
    exp_w32(8'h44, 32'h0000_FFFE);
    @(negedge clk);
    reset32 = 1'b0;
    drain32(1000);
    chk("halted32", 32'(halted32), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
